// File: rtl/ssp_pkg.sv
// ssp_pkg
// Shared definitions for the SSP transmit path.
//   SSP_DATA_WIDTH : serial word width, shared by the serializer and the
//                    transmit arbiter so both sides always agree.
//   arb_state_t    : transmit arbiter FSM encoding.
package ssp_pkg;

    localparam int SSP_DATA_WIDTH = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_SERVE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ssp_tx_fifo.sv
// ssp_tx_fifo
// Small synchronous FIFO that buffers words between the channel arbiter and
// the serializer. The occupancy is held in its own counter so that full and
// empty never depend on pointer comparison.
// Ports:
//   i_PCLK      clock, rising edge
//   i_CLEAR     asynchronous active-high reset; discards all contents
//   i_PUSH      write i_PUSH_DATA at the tail (ignored when full)
//   i_PUSH_DATA word to write
//   i_POP       drop the head entry (ignored when empty)
//   o_HEAD      current head entry, stable until the next pop
//   o_LEVEL     number of occupied entries
//   o_FULL      level equals DEPTH
//   o_EMPTY     level equals zero
module ssp_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int LVL_W     = $clog2(DEPTH + 1)
) (
    input  logic                  i_PCLK,
    input  logic                  i_CLEAR,
    input  logic                  i_PUSH,
    input  logic [DATA_WIDTH-1:0] i_PUSH_DATA,
    input  logic                  i_POP,
    output logic [DATA_WIDTH-1:0] o_HEAD,
    output logic [LVL_W-1:0]      o_LEVEL,
    output logic                  o_FULL,
    output logic                  o_EMPTY
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level;
    logic                  do_push;
    logic                  do_pop;

    assign o_FULL  = (level == LVL_W'(DEPTH));
    assign o_EMPTY = (level == '0);
    assign do_push = i_PUSH & ~o_FULL;
    assign do_pop  = i_POP & ~o_EMPTY;
    assign o_HEAD  = mem[rd_ptr];
    assign o_LEVEL = level;

    // Storage array. Entries are cleared on reset so the head output reads
    // zero until real data has been written to that slot.
    always_ff @(posedge i_PCLK or posedge i_CLEAR) begin
        if (i_CLEAR) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= i_PUSH_DATA;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. A push and a
    // pop in the same cycle move both pointers and leave the level alone.
    always_ff @(posedge i_PCLK or posedge i_CLEAR) begin
        if (i_CLEAR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ssp_tx_arbiter.sv
// ssp_tx_arbiter
// Transmit controller in front of the SSP serializer. Grants one channel at a
// time in round-robin order, accepts up to BURST_LEN contiguous words from the
// owner, buffers them in ssp_tx_fifo and hands the FIFO head to the
// serializer, popping one word per rising edge of the serializer request.
// Ports:
//   i_PCLK       clock, rising edge
//   i_CLEAR      asynchronous active-high reset
//   i_CH_EN      per-channel enable mask
//   i_CH_VALID   per-channel word-available flags
//   i_CH_DATA    channel k word in [k*DATA_WIDTH +: DATA_WIDTH]
//   o_CH_ACK     one-hot, word of that channel accepted this cycle
//   o_TXDATA     FIFO head to the serializer
//   o_TX_VALID   FIFO not empty
//   i_SER_REQ    serializer word request (held for two cycles)
//   o_FIFO_LEVEL occupied FIFO entries
//   o_BUSY       FIFO not empty or a channel currently owns the grant
//   o_UNDERRUN   sticky: a request arrived while the FIFO was empty
module ssp_tx_arbiter
    import ssp_pkg::*;
#(
    parameter int DATA_WIDTH = SSP_DATA_WIDTH,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int BURST_LEN  = 2,
    localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                         i_PCLK,
    input  logic                         i_CLEAR,
    input  logic [NUM_CH-1:0]            i_CH_EN,
    input  logic [NUM_CH-1:0]            i_CH_VALID,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_CH_DATA,
    output logic [NUM_CH-1:0]            o_CH_ACK,
    output logic [DATA_WIDTH-1:0]        o_TXDATA,
    output logic                         o_TX_VALID,
    input  logic                         i_SER_REQ,
    output logic [LVL_W-1:0]             o_FIFO_LEVEL,
    output logic                         o_BUSY,
    output logic                         o_UNDERRUN
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [CH_W-1:0]       owner;
    logic [CH_W-1:0]       owner_nxt;
    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       rr_ptr_nxt;
    logic [BC_W-1:0]       burst_cnt;
    logic [BC_W-1:0]       burst_cnt_nxt;
    logic [CH_W-1:0]       owner_wrap;
    logic [NUM_CH-1:0]     eligible;
    logic [CH_W-1:0]       winner;
    logic                  winner_found;
    logic [CH_W:0]         cand;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  ser_req_q;
    logic                  pop_edge;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign eligible   = i_CH_VALID & i_CH_EN;
    assign owner_wrap = (owner == CH_W'(NUM_CH - 1)) ? '0 : owner + 1'b1;
    assign push_data  = i_CH_DATA[int'(owner)*DATA_WIDTH +: DATA_WIDTH];

    // The serializer holds its request for two cycles, so only the rising
    // edge counts as a pop.
    assign pop_edge   = i_SER_REQ & ~ser_req_q;
    assign o_TX_VALID = ~fifo_empty;
    assign o_BUSY     = ~fifo_empty | (state != ARB_IDLE);

    ssp_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .i_PCLK      (i_PCLK),
        .i_CLEAR     (i_CLEAR),
        .i_PUSH      (push),
        .i_PUSH_DATA (push_data),
        .i_POP       (pop_edge & ~fifo_empty),
        .o_HEAD      (o_TXDATA),
        .o_LEVEL     (o_FIFO_LEVEL),
        .o_FULL      (fifo_full),
        .o_EMPTY     (fifo_empty)
    );

    // Round-robin search: first eligible channel at or above rr_ptr, wrapping
    // modulo NUM_CH (which need not be a power of two).
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        cand         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, rr_ptr} + (CH_W+1)'(i);
            if (cand >= (CH_W+1)'(NUM_CH)) begin
                cand = cand - (CH_W+1)'(NUM_CH);
            end
            if (!winner_found && eligible[cand[CH_W-1:0]]) begin
                winner_found = 1'b1;
                winner       = cand[CH_W-1:0];
            end
        end
    end

    // Arbiter next-state logic. The ack is Mealy so a word moves in the same
    // cycle the owner presents it. Losing valid/enable takes priority over a
    // full FIFO so a vanished owner never blocks other channels.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        o_CH_ACK      = '0;
        push          = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (winner_found) begin
                    owner_nxt     = winner;
                    burst_cnt_nxt = '0;
                    state_nxt     = ARB_SERVE;
                end
            end
            ARB_SERVE: begin
                if (!(i_CH_EN[owner] && i_CH_VALID[owner])) begin
                    state_nxt  = ARB_IDLE;
                    rr_ptr_nxt = owner_wrap;
                end else if (!fifo_full) begin
                    push            = 1'b1;
                    o_CH_ACK[owner] = 1'b1;
                    burst_cnt_nxt   = burst_cnt + 1'b1;
                    if (burst_cnt == BC_W'(BURST_LEN - 1)) begin
                        state_nxt  = ARB_IDLE;
                        rr_ptr_nxt = owner_wrap;
                    end
                end
            end
        endcase
    end

    // Arbiter state, request edge history and the sticky underrun flag.
    always_ff @(posedge i_PCLK or posedge i_CLEAR) begin
        if (i_CLEAR) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            ser_req_q  <= 1'b0;
            o_UNDERRUN <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
            ser_req_q <= i_SER_REQ;
            if (pop_edge && fifo_empty) begin
                o_UNDERRUN <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ssp_tx_arbiter.sv
// tb_ssp_tx_arbiter
// Directed bench for ssp_tx_arbiter (NUM_CH=4, FIFO_DEPTH=4, BURST_LEN=2).
// A per-cycle vector table covers the single-word path, request edge
// detection, underrun, masking and the full-FIFO stall; short hand-written
// sequences cover round-robin order, push/pop across pointer wrap, owner
// disable mid-burst and asynchronous reset.
module tb_ssp_tx_arbiter;

    logic        i_PCLK = 1'b0;
    logic        i_CLEAR;
    logic [3:0]  i_CH_EN;
    logic [3:0]  i_CH_VALID;
    logic [31:0] i_CH_DATA;
    logic [3:0]  o_CH_ACK;
    logic [7:0]  o_TXDATA;
    logic        o_TX_VALID;
    logic        i_SER_REQ;
    logic [2:0]  o_FIFO_LEVEL;
    logic        o_BUSY;
    logic        o_UNDERRUN;

    logic [17:0] outs;
    int          compared   = 0;
    int          mismatched = 0;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        req;
        logic [3:0]  ack;
        logic        txv;
        logic [7:0]  txd;
        logic [2:0]  lvl;
        logic        busy;
        logic        und;
    } vec_t;

    vec_t vecs [23];

    ssp_tx_arbiter #(
        .DATA_WIDTH (8),
        .NUM_CH     (4),
        .FIFO_DEPTH (4),
        .BURST_LEN  (2)
    ) dut (
        .i_PCLK       (i_PCLK),
        .i_CLEAR      (i_CLEAR),
        .i_CH_EN      (i_CH_EN),
        .i_CH_VALID   (i_CH_VALID),
        .i_CH_DATA    (i_CH_DATA),
        .o_CH_ACK     (o_CH_ACK),
        .o_TXDATA     (o_TXDATA),
        .o_TX_VALID   (o_TX_VALID),
        .i_SER_REQ    (i_SER_REQ),
        .o_FIFO_LEVEL (o_FIFO_LEVEL),
        .o_BUSY       (o_BUSY),
        .o_UNDERRUN   (o_UNDERRUN)
    );

    always #5 i_PCLK = ~i_PCLK;

    assign outs = {o_CH_ACK, o_TX_VALID, o_TXDATA, o_FIFO_LEVEL, o_BUSY, o_UNDERRUN};

    function automatic vec_t mk(input logic [3:0] en, input logic [3:0] valid,
                                input logic [31:0] data, input logic req,
                                input logic [3:0] ack, input logic txv,
                                input logic [7:0] txd, input logic [2:0] lvl,
                                input logic busy, input logic und);
        vec_t v;
        v.en = en; v.valid = valid; v.data = data; v.req = req;
        v.ack = ack; v.txv = txv; v.txd = txd; v.lvl = lvl;
        v.busy = busy; v.und = und;
        return v;
    endfunction

    // Drive all inputs for the cycle that is starting.
    task automatic applyStimulus(input logic [3:0] en, input logic [3:0] valid,
                                 input logic [31:0] data, input logic req);
        i_CH_EN    = en;
        i_CH_VALID = valid;
        i_CH_DATA  = data;
        i_SER_REQ  = req;
    endtask

    // One comparison: counts it and reports a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge i_PCLK);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(4'h0, 4'h0, 32'h0, 1'b0);
        i_CLEAR = 1'b1;
        tick();
        tick();
        i_CLEAR = 1'b0;
    endtask

    initial begin
        logic [3:0] rrAck [14];
        logic [3:0] wrReq;
        logic [7:0] wrData [10];
        logic [2:0] wrLvl [10];
        logic [7:0] wrTxd [10];
        logic [3:0] wrAck [10];
        logic [9:0] wrReqBits;

        i_CLEAR = 1'b0;
        applyStimulus(4'h0, 4'h0, 32'h0, 1'b0);

        // Per-cycle vectors: {en, valid, data, req} -> {ack, txv, txd, lvl, busy, und}
        vecs[0]  = mk(4'hF, 4'b0010, 32'h4433A511, 1'b0, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        vecs[1]  = mk(4'hF, 4'b0010, 32'h4433A511, 1'b0, 4'b0010, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        vecs[2]  = mk(4'hF, 4'b0000, 32'h4433A511, 1'b0, 4'b0000, 1'b1, 8'hA5, 3'd1, 1'b1, 1'b0);
        vecs[3]  = mk(4'hF, 4'b0000, 32'h4433A511, 1'b1, 4'b0000, 1'b1, 8'hA5, 3'd1, 1'b1, 1'b0);
        vecs[4]  = mk(4'hF, 4'b0000, 32'h4433A511, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        vecs[5]  = mk(4'hF, 4'b0000, 32'h4433A511, 1'b0, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        vecs[6]  = mk(4'hF, 4'b0000, 32'h4433A511, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        vecs[7]  = mk(4'hF, 4'b0000, 32'h4433A511, 1'b0, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        vecs[8]  = mk(4'hB, 4'b0100, 32'h4433A511, 1'b0, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        vecs[9]  = mk(4'hB, 4'b0100, 32'h4433A511, 1'b0, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        vecs[10] = mk(4'hF, 4'b0100, 32'h44C0A511, 1'b0, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        vecs[11] = mk(4'hF, 4'b0100, 32'h44C0A511, 1'b0, 4'b0100, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
        vecs[12] = mk(4'hF, 4'b0100, 32'h44C1A511, 1'b0, 4'b0100, 1'b1, 8'hC0, 3'd1, 1'b1, 1'b1);
        vecs[13] = mk(4'hF, 4'b0100, 32'h44C2A511, 1'b0, 4'b0000, 1'b1, 8'hC0, 3'd2, 1'b1, 1'b1);
        vecs[14] = mk(4'hF, 4'b0100, 32'h44C2A511, 1'b0, 4'b0100, 1'b1, 8'hC0, 3'd2, 1'b1, 1'b1);
        vecs[15] = mk(4'hF, 4'b0100, 32'h44C3A511, 1'b0, 4'b0100, 1'b1, 8'hC0, 3'd3, 1'b1, 1'b1);
        vecs[16] = mk(4'hF, 4'b0100, 32'h44C4A511, 1'b0, 4'b0000, 1'b1, 8'hC0, 3'd4, 1'b1, 1'b1);
        vecs[17] = mk(4'hF, 4'b0100, 32'h44C4A511, 1'b0, 4'b0000, 1'b1, 8'hC0, 3'd4, 1'b1, 1'b1);
        vecs[18] = mk(4'hF, 4'b0100, 32'h44C4A511, 1'b1, 4'b0000, 1'b1, 8'hC0, 3'd4, 1'b1, 1'b1);
        vecs[19] = mk(4'hF, 4'b0100, 32'h44C4A511, 1'b1, 4'b0100, 1'b1, 8'hC1, 3'd3, 1'b1, 1'b1);
        vecs[20] = mk(4'hF, 4'b0000, 32'h44C4A511, 1'b0, 4'b0000, 1'b1, 8'hC1, 3'd4, 1'b1, 1'b1);
        vecs[21] = mk(4'hF, 4'b0000, 32'h44C4A511, 1'b1, 4'b0000, 1'b1, 8'hC1, 3'd4, 1'b1, 1'b1);
        vecs[22] = mk(4'hF, 4'b0000, 32'h44C4A511, 1'b0, 4'b0000, 1'b1, 8'hC2, 3'd3, 1'b1, 1'b1);

        $display("[TB] vector table");
        doReset();
        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].en, vecs[i].valid, vecs[i].data, vecs[i].req);
            #1;
            checkOutput($sformatf("vec%0d", i), 64'(outs),
                        64'({vecs[i].ack, vecs[i].txv, vecs[i].txd, vecs[i].lvl,
                             vecs[i].busy, vecs[i].und}));
            tick();
        end

        // Round-robin with every channel valid and the serializer draining
        // on every other cycle: two acks per owner, one idle cycle between.
        $display("[TB] round-robin");
        rrAck = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0,
                  4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1};
        doReset();
        for (int c = 0; c < 14; c++) begin
            applyStimulus(4'hF, 4'hF, 32'h44332211, (c >= 2) && (c % 2 == 0));
            #1;
            checkOutput($sformatf("rr_ack_c%0d", c), 64'(o_CH_ACK), 64'(rrAck[c]));
            tick();
        end

        // Pushes and pops coinciding, including a write at the wrapped address.
        $display("[TB] push/pop across wrap");
        wrReqBits = 10'b0010010100;
        wrData = '{8'h10, 8'h10, 8'h11, 8'h12, 8'h12, 8'h13, 8'h14, 8'h14, 8'h15, 8'h15};
        wrLvl  = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3};
        wrTxd  = '{8'h00, 8'h00, 8'h10, 8'h11, 8'h11, 8'h12, 8'h12, 8'h12, 8'h13, 8'h13};
        wrAck  = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0};
        doReset();
        for (int c = 0; c < 10; c++) begin
            wrReq = (c < 9) ? 4'b0001 : 4'b0000;
            applyStimulus(4'h1, wrReq, {24'h0, wrData[c]}, wrReqBits[c]);
            #1;
            checkOutput($sformatf("wrap_c%0d", c), 64'({o_CH_ACK, o_FIFO_LEVEL, o_TXDATA}),
                        64'({wrAck[c], wrLvl[c], wrTxd[c]}));
            tick();
        end
        checkOutput("wrap_no_underrun", 64'(o_UNDERRUN), 64'h0);

        // Owner disabled after its first word: released with no further ack.
        $display("[TB] owner disable mid-burst");
        doReset();
        applyStimulus(4'hF, 4'b0001, 32'h000000EE, 1'b0);
        tick();
        #1;
        checkOutput("dis_first_ack", 64'(o_CH_ACK), 64'h1);
        tick();
        applyStimulus(4'hE, 4'b0001, 32'h000000EF, 1'b0);
        #1;
        checkOutput("dis_release", 64'(o_CH_ACK), 64'h0);
        tick();
        #1;
        checkOutput("dis_idle", 64'({o_CH_ACK, o_FIFO_LEVEL}), 64'({4'h0, 3'd1}));
        tick();

        // Asynchronous reset with three words queued and ch3 mid-burst.
        $display("[TB] reset mid-operation");
        doReset();
        applyStimulus(4'h8, 4'h8, 32'hAB000000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
        end
        #1;
        checkOutput("rst_pre", 64'({o_CH_ACK, o_FIFO_LEVEL, o_BUSY}), 64'({4'h8, 3'd3, 1'b1}));
        i_CLEAR = 1'b1;
        #1;
        checkOutput("rst_async", 64'(outs), 64'h0);
        applyStimulus(4'hF, 4'hF, 32'h44332211, 1'b0);
        #1;
        i_CLEAR = 1'b0;
        tick();
        #1;
        checkOutput("rst_first_grant", 64'(o_CH_ACK), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
